serial_adder_ctrl: RTL and testbench

//  Sequencer for the bit-serial Mealy adder: accepts two WIDTH-bit operands over a valid/ready port,

---
 rtl/serial_adder_ctrl.sv | 163 ++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Word-level sequencer for one external bit-serial Mealy adder: captures an operand pair,
// streams it LSB-first through the adder, and returns the WIDTH-bit sum.
// Optional macro CARRY_OUT_EN adds a FLUSH cycle that captures the final carry on Cout.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Op_A,
  input  logic [WIDTH-1:0] Op_B,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Busy,
  output logic             Add_A,
  output logic             Add_B,
  output logic             Add_En,
  output logic             Add_Rst,
  input  logic             Add_S
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [CW-1:0]    r_cnt;
  logic             w_add_a;
  logic             w_add_b;
  logic             w_add_en;
  logic             w_accept;

  assign w_accept  = (r_state == S_IDLE) && In_Valid;
  assign In_Ready  = (r_state == S_IDLE);
  assign Busy      = (r_state != S_IDLE);
  assign Out_Valid = (r_state == S_DONE);
  assign Sum       = r_sum_sh;
  assign Add_A     = w_add_a;
  assign Add_B     = w_add_b;
  assign Add_En    = w_add_en;
  // Adder is held in reset alongside the controller as well as during CLEAR.
  assign Add_Rst   = ~Reset | (r_state == S_CLEAR);

`ifdef CARRY_OUT_EN
  logic r_cout;
  assign Cout = r_cout;
`else
  assign Cout = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_cnt    <= '0;
`ifdef CARRY_OUT_EN
      r_cout   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sh <= Op_A;
            r_b_sh <= Op_B;
            r_cnt  <= '0;
`ifdef CARRY_OUT_EN
            r_cout <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          r_sum_sh <= {Add_S, r_sum_sh[WIDTH-1:1]};
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef CARRY_OUT_EN
        S_FLUSH: begin
          r_cout <= Add_S;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    w_add_a  = 1'b0;
    w_add_b  = 1'b0;
    w_add_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_CLEAR;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_add_a  = r_a_sh[0];
        w_add_b  = r_b_sh[0];
        w_add_en = 1'b1;
        if (r_cnt == LAST) begin
`ifdef CARRY_OUT_EN
          w_next = S_FLUSH;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_SHIFT;
        end
      end
`ifdef CARRY_OUT_EN
      // Zero operand bits so the adder's sum output is just the final carry.
      S_FLUSH: begin
        w_add_en = 1'b1;
        w_next   = S_DONE;
      end
`endif
      S_DONE: begin
        if (Out_Ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8) with a behavioural serial Mealy adder.
// Works with or without CARRY_OUT_EN defined.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;
`ifdef CARRY_OUT_EN
  localparam int LAT = WIDTH + 2;
  localparam bit HAS_COUT = 1'b1;
`else
  localparam int LAT = WIDTH + 1;
  localparam bit HAS_COUT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] Op_A;
  logic [WIDTH-1:0] Op_B;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Busy;
  logic             Add_A;
  logic             Add_B;
  logic             Add_En;
  logic             Add_Rst;
  logic             Add_S;
  logic             carry;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Op_A(Op_A), .Op_B(Op_B), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Sum(Sum), .Cout(Cout), .Busy(Busy), .Add_A(Add_A), .Add_B(Add_B),
    .Add_En(Add_En), .Add_Rst(Add_Rst), .Add_S(Add_S)
  );

  always #5 Clock = ~Clock;

  // Behavioural serial adder: Mealy sum, carry flop with active-high reset and enable.
  assign Add_S = Add_A ^ Add_B ^ carry;
  always @(posedge Clock) begin
    if (Add_Rst) carry <= 1'b0;
    else if (Add_En) carry <= (Add_A & Add_B) | (Add_A & carry) | (Add_B & carry);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    exp_t e;
    int n;
    Op_A = a;
    Op_B = b;
    In_Valid = 1'b1;
    n = 0;
    while (!In_Ready && n < 40) begin
      tick();
      n++;
    end
    check_eq("in_ready_before_accept", In_Ready, 1);
    tick();
    cyc = 0;
    In_Valid = 1'b0;
    full = {1'b0, a} + {1'b0, b};
    e.sum = full[7:0];
    e.cout = HAS_COUT ? full[8] : 1'b0;
    sb_q.push_back(e);
    check_eq("busy_after_accept", Busy, 1);
    check_eq("in_ready_after_accept", In_Ready, 0);
  endtask

  task automatic wait_result(input int hold);
    exp_t e;
    int n;
    n = 0;
    while (!Out_Valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("out_valid_seen", Out_Valid, 1);
    check_eq("latency", cyc, LAT);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '0;
    check_eq("sum", Sum, e.sum);
    check_eq("cout", Cout, e.cout);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("hold_valid", Out_Valid, 1);
      check_eq("hold_sum", Sum, e.sum);
      check_eq("hold_cout", Cout, e.cout);
      check_eq("hold_in_ready", In_Ready, 0);
      check_eq("hold_add_en", Add_En, 0);
    end
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    check_eq("idle_after_take", In_Ready, 1);
    check_eq("valid_dropped", Out_Valid, 0);
  endtask

  initial begin
    Reset = 1'b0;
    In_Valid = 1'b0;
    Op_A = '0;
    Op_B = '0;
    Out_Ready = 1'b0;
    tick();
    tick();
    check_eq("rst_add_rst", Add_Rst, 1);
    Reset = 1'b1;
    tick();
    check_eq("rst_in_ready", In_Ready, 1);
    check_eq("rst_out_valid", Out_Valid, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_sum", Sum, 0);
    check_eq("rst_cout", Cout, 0);
    check_eq("rst_add_en", Add_En, 0);
    check_eq("rst_add_rst_released", Add_Rst, 0);

    // Basic sum and latency
    send(8'h5A, 8'h3C);
    wait_result(0);
    // Overflow: carry visible only with the macro
    send(8'hFF, 8'h01);
    wait_result(0);
    // Backpressure in DONE
    send(8'h5A, 8'h3C);
    wait_result(5);

    // In_Valid during SHIFT is ignored
    send(8'h21, 8'h42);
    tick();
    tick();
    check_eq("shift_add_en", Add_En, 1);
    Op_A = 8'h11;
    Op_B = 8'h11;
    In_Valid = 1'b1;
    check_eq("shift_in_ready", In_Ready, 0);
    tick();
    In_Valid = 1'b0;
    wait_result(0);

    // Reset at SHIFT cnt=3 discards the transaction
    send(8'h12, 8'h34);
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b0;
    #1;
    check_eq("midrst_add_rst", Add_Rst, 1);
    tick();
    Reset = 1'b1;
    void'(sb_q.pop_back());
    check_eq("midrst_in_ready", In_Ready, 1);
    check_eq("midrst_out_valid", Out_Valid, 0);
    check_eq("midrst_busy", Busy, 0);
    check_eq("midrst_cout", Cout, 0);
    send(8'h01, 8'h02);
    wait_result(0);

    // Back-to-back; second op must start with a cleared carry
    send(8'h80, 8'h80);
    wait_result(0);
    send(8'h0F, 8'hF0);
    wait_result(0);

    // Randomised operands
    for (int k = 0; k < 6; k++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_result(k % 3);
    end

    check_eq("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
